// File: rtl/dtree_channel_scheduler_if.sv
// Bus bundle for dtree_channel_scheduler: per-channel sample inputs,
// the classifier stream/result handshake and the tagged result outputs.
//
// Handshake: a sample moves to the classifier on a cycle where
// cls_in_valid and cls_ready are both high at the rising edge. While
// cls_in_valid is high and cls_ready is low, cls_sample holds its value
// and cls_in_valid stays asserted. ch_valid and cls_out_valid are plain
// strobes with no backpressure.
interface dtree_channel_scheduler_if #(
    parameter int CHANNELS = 4,
    parameter int FEATURES = 3,
    parameter int IN_WIDTH = 10
);
    localparam int CW = $clog2(CHANNELS);
    localparam int LW = $clog2(FEATURES);

    logic [CHANNELS-1:0]          ch_valid;
    logic [CHANNELS*IN_WIDTH-1:0] ch_sample;
    logic                         cls_in_valid;
    logic                         cls_ready;
    logic [IN_WIDTH-1:0]          cls_sample;
    logic [LW-1:0]                cls_level;
    logic [LW-1:0]                cls_path;
    logic                         cls_out_valid;
    logic                         res_valid;
    logic [CW-1:0]                res_channel;
    logic [LW-1:0]                res_level;
    logic [LW-1:0]                res_path;
    logic [CHANNELS-1:0]          drop;

    // Scheduler side
    modport master (
        input  ch_valid, ch_sample, cls_ready, cls_level, cls_path, cls_out_valid,
        output cls_in_valid, cls_sample, res_valid, res_channel, res_level, res_path, drop
    );

    // Environment side: front ends, classifier and result consumer
    modport slave (
        output ch_valid, ch_sample, cls_ready, cls_level, cls_path, cls_out_valid,
        input  cls_in_valid, cls_sample, res_valid, res_channel, res_level, res_path, drop
    );
endinterface

// File: rtl/dtree_channel_scheduler.sv
// Round-robin time-sharing of one decision-tree classifier between
// CHANNELS sample windows. Each channel fills a FEATURES-deep window;
// a full window is granted, streamed oldest-first, and the classifier
// result is returned tagged with the channel index.
// Optional macro DTREE_SCHED_DROP_CNT_EN adds per-channel saturating
// 8-bit drop counters on output drop_count.
module dtree_channel_scheduler #(
    parameter int CHANNELS = 4,
    parameter int FEATURES = 3,
    parameter int IN_WIDTH = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    dtree_channel_scheduler_if.master     bus,
    output logic [1:0]                    dbg_state
`ifdef DTREE_SCHED_DROP_CNT_EN
    ,
    output logic [CHANNELS*8-1:0]         drop_count
`endif
);
    localparam int CW = $clog2(CHANNELS);
    localparam int LW = $clog2(FEATURES);
    localparam int NW = $clog2(FEATURES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       gnt_q, gnt_d;
    logic [CW-1:0]       rr_q, rr_d;
    logic [LW-1:0]       idx_q, idx_d;
    logic [NW-1:0]       count_q [CHANNELS];
    logic [NW-1:0]       count_d [CHANNELS];
    logic [IN_WIDTH-1:0] win_q [CHANNELS][FEATURES];
    logic [IN_WIDTH-1:0] win_d [CHANNELS][FEATURES];
    logic [CHANNELS-1:0] drop_q, drop_d;
    logic                res_valid_q, res_valid_d;
    logic [CW-1:0]       res_channel_q, res_channel_d;
    logic [LW-1:0]       res_level_q, res_level_d;
    logic [LW-1:0]       res_path_q, res_path_d;

    logic [CHANNELS-1:0] pending;
    logic                any_pending;
    logic [CW-1:0]       pick;
    logic                last_hs;
    logic [NW-1:0]       eff_count;

    // The window of the granted channel is released on the final handshake
    assign last_hs = (state_q == STREAM) && bus.cls_ready && (idx_q == LW'(FEATURES - 1));

    // A window is pending exactly when it holds FEATURES samples
    always_comb begin
        pending = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pending[i] = (count_q[i] == NW'(FEATURES));
        end
    end

    // First pending channel at or after rr_q, wrapping; lowest offset wins
    always_comb begin
        any_pending = 1'b0;
        pick        = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (pending[(int'(rr_q) + k) % CHANNELS]) begin
                any_pending = 1'b1;
                pick        = CW'((int'(rr_q) + k) % CHANNELS);
            end
        end
    end

    // Window fill and overflow drop; a release frees the slot in the same cycle
    always_comb begin
        count_d   = count_q;
        win_d     = win_q;
        drop_d    = '0;
        eff_count = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            eff_count = count_q[i];
            if (last_hs && (gnt_q == CW'(i))) begin
                eff_count = '0;
            end
            if (bus.ch_valid[i]) begin
                if (eff_count == NW'(FEATURES)) begin
                    drop_d[i] = 1'b1;
                end else begin
                    win_d[i][eff_count] = bus.ch_sample[i*IN_WIDTH +: IN_WIDTH];
                    eff_count           = eff_count + NW'(1);
                end
            end
            count_d[i] = eff_count;
        end
    end

    // Scheduler FSM: grant, stream the window, wait for the classifier result
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        idx_d         = idx_q;
        rr_d          = rr_q;
        res_valid_d   = 1'b0;
        res_channel_d = res_channel_q;
        res_level_d   = res_level_q;
        res_path_d    = res_path_q;
        unique case (state_q)
            IDLE: begin
                if (any_pending) begin
                    gnt_d   = pick;
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (bus.cls_ready) begin
                    if (idx_q == LW'(FEATURES - 1)) begin
                        state_d = WAIT;
                    end else begin
                        idx_d = idx_q + LW'(1);
                    end
                end
            end
            WAIT: begin
                if (bus.cls_out_valid) begin
                    res_valid_d   = 1'b1;
                    res_channel_d = gnt_q;
                    res_level_d   = bus.cls_level;
                    res_path_d    = bus.cls_path;
                    rr_d          = (gnt_q == CW'(CHANNELS - 1)) ? '0 : gnt_q + CW'(1);
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and storage registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            rr_q          <= '0;
            idx_q         <= '0;
            drop_q        <= '0;
            res_valid_q   <= 1'b0;
            res_channel_q <= '0;
            res_level_q   <= '0;
            res_path_q    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i] <= '0;
                for (int j = 0; j < FEATURES; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            rr_q          <= rr_d;
            idx_q         <= idx_d;
            drop_q        <= drop_d;
            res_valid_q   <= res_valid_d;
            res_channel_q <= res_channel_d;
            res_level_q   <= res_level_d;
            res_path_q    <= res_path_d;
            count_q       <= count_d;
            win_q         <= win_d;
        end
    end

    assign bus.cls_in_valid = (state_q == STREAM);
    assign bus.cls_sample   = (state_q == STREAM) ? win_q[gnt_q][idx_q] : '0;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_channel  = res_channel_q;
    assign bus.res_level    = res_level_q;
    assign bus.res_path     = res_path_q;
    assign bus.drop         = drop_q;
    assign dbg_state        = state_q;

`ifdef DTREE_SCHED_DROP_CNT_EN
    logic [7:0] dcnt_q [CHANNELS];
    logic [7:0] dcnt_d [CHANNELS];

    // Saturating drop counters, advanced by the registered drop pulse
    always_comb begin
        dcnt_d     = dcnt_q;
        drop_count = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (drop_q[i] && (dcnt_q[i] != 8'hFF)) begin
                dcnt_d[i] = dcnt_q[i] + 8'd1;
            end
            drop_count[i*8 +: 8] = dcnt_q[i];
        end
    end

    // Drop counter registers, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                dcnt_q[i] <= '0;
            end
        end else begin
            dcnt_q <= dcnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_dtree_channel_scheduler.sv
// Scoreboard bench for dtree_channel_scheduler: directed windows, a small
// classifier model with fixed latency, and a negedge monitor that pops
// expected samples, results and drops as the DUT presents them.
module tb_dtree_channel_scheduler;
    localparam int CHANNELS = 4;
    localparam int FEATURES = 3;
    localparam int IN_WIDTH = 10;
    localparam int CW = $clog2(CHANNELS);
    localparam int LW = $clog2(FEATURES);
    localparam int RW = CW + 2 * LW;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;
`ifdef DTREE_SCHED_DROP_CNT_EN
    logic [CHANNELS*8-1:0] drop_count;
`endif

    dtree_channel_scheduler_if #(.CHANNELS(CHANNELS), .FEATURES(FEATURES), .IN_WIDTH(IN_WIDTH)) bus ();

    dtree_channel_scheduler #(.CHANNELS(CHANNELS), .FEATURES(FEATURES), .IN_WIDTH(IN_WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
`ifdef DTREE_SCHED_DROP_CNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [IN_WIDTH-1:0] exp_q[$];
    logic [RW-1:0]       exp_res_q[$];
    logic [CW-1:0]       exp_drop_q[$];
    logic [2*LW-1:0]     cls_resp_q[$];
    int                  hs_cyc_q[$];
    int                  checks = 0;
    int                  failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got %0d with nothing expected (t=%0t)", name, act, $time);
    endtask

    // Driver tasks: all start and end at posedge+1
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int ch, input logic [IN_WIDTH-1:0] v);
        bus.ch_valid = '0;
        bus.ch_valid[ch] = 1'b1;
        bus.ch_sample[ch*IN_WIDTH +: IN_WIDTH] = v;
        tick();
        bus.ch_valid = '0;
    endtask

    task automatic put2(input int ca, input logic [IN_WIDTH-1:0] va,
                        input int cb, input logic [IN_WIDTH-1:0] vb);
        bus.ch_valid = '0;
        bus.ch_valid[ca] = 1'b1;
        bus.ch_valid[cb] = 1'b1;
        bus.ch_sample[ca*IN_WIDTH +: IN_WIDTH] = va;
        bus.ch_sample[cb*IN_WIDTH +: IN_WIDTH] = vb;
        tick();
        bus.ch_valid = '0;
    endtask

    task automatic expect_window(input logic [IN_WIDTH-1:0] a, b, c);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
    endtask

    task automatic expect_result(input int ch, input int lvl, input int pth);
        cls_resp_q.push_back({LW'(lvl), LW'(pth)});
        exp_res_q.push_back({CW'(ch), LW'(lvl), LW'(pth)});
    endtask

    task automatic wait_until_sample(input string name, input logic [IN_WIDTH-1:0] v);
        int n = 0;
        while (!(bus.cls_in_valid && bus.cls_sample == v) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) flag({name, "_timeout"}, n);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || exp_res_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) flag({name, "_drain_timeout"}, exp_q.size() + exp_res_q.size());
        repeat (3) tick();
    endtask

    // Classifier model: after FEATURES handshakes, answer two cycles later
    initial begin : classifier
        int hs_cnt;
        logic [2*LW-1:0] r;
        hs_cnt = 0;
        bus.cls_out_valid = 1'b0;
        bus.cls_level = '0;
        bus.cls_path = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hs_cnt = 0;
            end else if (bus.cls_in_valid && bus.cls_ready) begin
                hs_cnt++;
                if (hs_cnt == FEATURES) begin
                    hs_cnt = 0;
                    repeat (2) @(posedge clk);
                    #1;
                    r = '0;
                    if (cls_resp_q.size() != 0) r = cls_resp_q.pop_front();
                    else flag("classifier_resp", 0);
                    bus.cls_level = r[2*LW-1:LW];
                    bus.cls_path = r[LW-1:0];
                    bus.cls_out_valid = 1'b1;
                    @(posedge clk);
                    #1;
                    bus.cls_out_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an output
    initial begin : monitor
        logic [IN_WIDTH-1:0] prev_sample;
        logic prev_stall;
        prev_sample = '0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (bus.cls_in_valid && prev_stall) check("stall_stable", bus.cls_sample, prev_sample);
                if (bus.cls_in_valid && bus.cls_ready) begin
                    hs_cyc_q.push_back(cyc);
                    if (exp_q.size() == 0) flag("sample_unexpected", bus.cls_sample);
                    else check("sample", bus.cls_sample, exp_q.pop_front());
                end
                prev_stall = bus.cls_in_valid && !bus.cls_ready;
                prev_sample = bus.cls_sample;
                if (bus.res_valid) begin
                    if (exp_res_q.size() == 0) flag("result_unexpected", {bus.res_channel, bus.res_level, bus.res_path});
                    else check("result", {bus.res_channel, bus.res_level, bus.res_path}, exp_res_q.pop_front());
                end
                for (int i = 0; i < CHANNELS; i++) begin
                    if (bus.drop[i]) begin
                        if (exp_drop_q.size() == 0) flag("drop_unexpected", i);
                        else check("drop_channel", i, exp_drop_q.pop_front());
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        reset = 1'b1;
        bus.ch_valid = '0;
        bus.ch_sample = '0;
        bus.cls_ready = 1'b1;
        repeat (3) tick();
        check("rst_in_valid", bus.cls_in_valid, 0);
        check("rst_sample", bus.cls_sample, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_channel", bus.res_channel, 0);
        check("rst_res_level", bus.res_level, 0);
        check("rst_res_path", bus.res_path, 0);
        check("rst_drop", bus.drop, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b0;

        // 1: single channel, back-to-back stream
        hs_cyc_q.delete();
        expect_window(5, 7, 9);
        expect_result(2, 1, 2);
        put(2, 5); put(2, 7); put(2, 9);
        wait_drain("single");
        check("single_hs_count", hs_cyc_q.size(), 3);
        if (hs_cyc_q.size() == 3) check("single_hs_span", hs_cyc_q[2] - hs_cyc_q[0], 2);
        check("single_res_hold", {bus.res_channel, bus.res_level, bus.res_path}, {2'd2, 2'd1, 2'd2});

        // 2: contention from reset, then rotation after serving ch 0
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        expect_window(10, 11, 12); expect_result(0, 0, 1);
        expect_window(20, 21, 22); expect_result(1, 1, 0);
        put2(0, 10, 1, 20); put2(0, 11, 1, 21); put2(0, 12, 1, 22);
        wait_drain("contention_a");
        expect_window(30, 31, 32); expect_result(0, 2, 2);
        put(0, 30); put(0, 31); put(0, 32);
        wait_drain("contention_b");
        expect_window(50, 51, 52); expect_result(1, 3, 0);
        expect_window(40, 41, 42); expect_result(0, 1, 3);
        put2(0, 40, 1, 50); put2(0, 41, 1, 51); put2(0, 42, 1, 52);
        wait_drain("contention_c");

        // 3: backpressure on the second sample
        bus.cls_ready = 1'b0;
        expect_window(60, 61, 62); expect_result(3, 2, 1);
        put(3, 60); put(3, 61); put(3, 62);
        wait_until_sample("bp_grant", 60);
        bus.cls_ready = 1'b1;
        tick();
        bus.cls_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp_hold_valid", bus.cls_in_valid, 1);
            check("bp_hold_sample", bus.cls_sample, 61);
            tick();
        end
        bus.cls_ready = 1'b1;
        wait_drain("backpressure");

        // 4: overflow on a pending, not-yet-granted window
        bus.cls_ready = 1'b0;
        expect_window(70, 71, 72); expect_result(1, 0, 2);
        expect_window(80, 81, 82); expect_result(3, 3, 3);
        put(1, 70); put(1, 71); put(1, 72);
        wait_until_sample("ovf_grant", 70);
        exp_drop_q.push_back(2'd3);
        put(3, 80); put(3, 81); put(3, 82); put(3, 83);
        tick(); tick();
        check("ovf_drop_seen", exp_drop_q.size(), 0);
        bus.cls_ready = 1'b1;
        wait_drain("overflow");
`ifdef DTREE_SCHED_DROP_CNT_EN
        check("ovf_drop_count3", drop_count[3*8 +: 8], 1);
        check("ovf_drop_count1", drop_count[1*8 +: 8], 0);
`endif

        // 5: refill of the granted channel on its final handshake
        expect_window(90, 91, 92); expect_result(2, 1, 1);
        expect_window(93, 94, 95); expect_result(2, 2, 0);
        put(2, 90); put(2, 91); put(2, 92);
        wait_until_sample("refill_last", 92);
        put(2, 93); put(2, 94); put(2, 95);
        wait_drain("refill");

        // 6: reset in STREAM after one handshake
        put(0, 99);
        expect_window(100, 101, 102); expect_result(1, 0, 0);
        put(1, 100); put(1, 101); put(1, 102);
        wait_until_sample("rst_mid", 101);
        reset = 1'b1;
        tick();
        check("rst_mid_in_valid", bus.cls_in_valid, 0);
        check("rst_mid_res_valid", bus.res_valid, 0);
        check("rst_mid_state", dbg_state, 0);
        check("rst_mid_res_level", bus.res_level, 0);
        exp_q.delete();
        exp_res_q.delete();
        cls_resp_q.delete();
        tick();
        reset = 1'b0;
        expect_window(110, 111, 112); expect_result(0, 3, 1);
        put(0, 110); put(0, 111); put(0, 112);
        wait_drain("post_reset");
        repeat (10) tick();

        check("end_exp_q_empty", exp_q.size(), 0);
        check("end_res_q_empty", exp_res_q.size(), 0);
        check("end_drop_q_empty", exp_drop_q.size(), 0);
        check("end_resp_q_empty", cls_resp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dtree_channel_scheduler.md
Name: dtree_channel_scheduler

Overview:
Time-shares one decision-tree spike classifier between CHANNELS electrode channels. Each channel has a FEATURES-deep sample window that fills from a free-running ADC stream. A round-robin scheduler grants a full window to the classifier, streams it over the classifier's valid/ready handshake, and captures the classifier's level/path result. The result is returned tagged with the channel index. Sits between the per-channel front ends and the single shared classifier instance.

Parameters:
CHANNELS, 4, number of requesting channels (>=2)
FEATURES, 3, samples per classification window; must match the classifier
IN_WIDTH, 10, sample width in bits

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
ch_valid  input  CHANNELS  per-channel sample strobe; no backpressure
ch_sample  input  CHANNELS*IN_WIDTH  channel i occupies bits [i*IN_WIDTH +: IN_WIDTH]
cls_in_valid  output  1  sample valid to classifier
cls_ready  input  1  classifier ready
cls_sample  output  IN_WIDTH  sample to classifier
cls_level  input  $clog2(FEATURES)  classifier result level
cls_path  input  $clog2(FEATURES)  classifier result path
cls_out_valid  input  1  classifier result strobe
res_valid  output  1  one-cycle result pulse
res_channel  output  $clog2(CHANNELS)  channel the result belongs to
res_level  output  $clog2(FEATURES)  registered cls_level
res_path  output  $clog2(FEATURES)  registered cls_path
drop  output  CHANNELS  one-cycle pulse per channel when a sample is discarded

Behaviour:
- Reset: synchronous, active-high; clock clk. All outputs 0, all windows empty, FSM IDLE, rr pointer 0. Reset mid-stream aborts the transfer and discards any pending windows.
- Per-channel window: fill count 0..FEATURES and a pending flag. On ch_valid[i] with pending=0, the sample is written at index count and count increments. When count reaches FEATURES, pending is set.
- ch_valid[i] with pending=1: the sample is discarded and drop[i] pulses the next cycle.
- FSM states:
  - IDLE: if any window is pending, grant the first pending channel at or after rr_ptr (wrapping). Register gnt and go to STREAM. cls_in_valid rises the cycle after the grant decision. No pending window: stay in IDLE.
  - STREAM: cls_in_valid=1 and cls_sample=window[gnt][idx], oldest sample first (idx 0). idx advances only on cls_in_valid & cls_ready. cls_sample must stay stable while cls_ready=0. On the handshake at idx=FEATURES-1: clear pending[gnt], reset count[gnt] to 0, go to WAIT.
  - WAIT: cls_in_valid=0. On cls_out_valid, register level/path and gnt into the res_* outputs, pulse res_valid the next cycle, set rr_ptr=gnt+1 (mod CHANNELS), go to IDLE.
- Simultaneous events:
  - ch_valid[gnt] on the cycle of the final handshake: the sample goes to index 0 and count becomes 1; it is not dropped.
  - Refill of the granted channel is allowed during WAIT.
  - cls_out_valid outside WAIT is ignored.
- Throughput floor: grant to result = 1 + FEATURES + classifier latency cycles, plus 1 cycle to res_valid.
- res_level, res_path and res_channel hold their values until the next result.

Optional Feature:
DTREE_SCHED_DROP_CNT_EN
- Defined: adds output drop_count (CHANNELS*8 bits), one saturating 8-bit counter per channel. Each counter increments on that channel's drop pulse and sticks at 255. Counters clear only on reset.
- Undefined: no port and no counters; the drop pulses are unchanged.

Test Plan:
1. Single channel: ch 2 delivers 5, 7, 9 with cls_ready=1. Required: cls_sample 5, 7, 9 on consecutive cycles. Classifier returns level=1, path=2 → res_valid pulse with res_channel=2, res_level=1, res_path=2.
2. Contention: ch 0 and ch 1 complete windows on the same cycle after reset. Required: ch 0 is streamed first, then ch 1. Next time both are pending, ch 1 is served before ch 0.
3. Backpressure: hold cls_ready=0 for 4 cycles during the second sample. Required: cls_sample stays on that value throughout, with no duplicate and no skipped sample.
4. Overflow: ch 3 pending and not granted, then a 4th ch_valid arrives. Required: drop[3] pulses once, and the window still streams its original 3 samples.
5. Refill boundary: ch_valid[gnt] on the final-handshake cycle. Required: no drop, and the next window for that channel starts with that sample.
6. Reset in STREAM after 1 handshake. Required: the next cycle has cls_in_valid=0, res_valid=0, and all windows empty; the first post-reset window from ch 0 streams normally.
